// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one synchronous single-port data
// memory between NUM_CORES cores. Grant and memory command are registered on
// the same edge; the acknowledge (plus read data) follows two cycles later.
// Optional lock mode, compiled in with `define ARB_LOCK_EN, lets one core take
// back-to-back grants for up to LOCK_MAX accesses.
module dmem_arbiter #(
   parameter int NUM_CORES = 4,
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 16,
   parameter int LOCK_MAX  = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CORES-1:0]        core_req,
   input  logic [NUM_CORES-1:0]        core_wr,
   input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
   input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
   input  logic [NUM_CORES-1:0]        core_lock,
   output logic [NUM_CORES-1:0]        core_gnt,
   output logic [NUM_CORES-1:0]        core_ack,
   output logic [DATA_W-1:0]           core_rdata,
   output logic                        mem_en,
   output logic                        mem_wr,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_wdata,
   input  logic [DATA_W-1:0]           mem_rdata,
   output logic                        busy
);

   localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   typedef enum logic [0:0] {ST_ARB, ST_LOCKED} state_t;

   // Round-robin position wrap for the search order ptr+1, ptr+2, ...
   function automatic logic [IDX_W-1:0] wrap_idx(input int v);
      return IDX_W'(v % NUM_CORES);
   endfunction

   state_t                r_state;
   state_t                w_state_nxt;
   logic [IDX_W-1:0]      r_ptr;
   logic [NUM_CORES-1:0]  r_gnt;
   logic [NUM_CORES-1:0]  r_s1_gnt;
   logic                  r_s1_rd;
   logic [NUM_CORES-1:0]  r_ack;
   logic [DATA_W-1:0]     r_rdata;
   logic                  r_mem_en;
   logic                  r_mem_wr;
   logic [ADDR_W-1:0]     r_mem_addr;
   logic [DATA_W-1:0]     r_mem_wdata;

   logic [NUM_CORES-1:0]  w_elig;
   logic                  w_found;
   logic [IDX_W-1:0]      w_srch_idx;
   logic                  w_gnt_vld;
   logic [IDX_W-1:0]      w_gnt_idx;

`ifdef ARB_LOCK_EN
   localparam int CNT_W = $clog2(LOCK_MAX + 1);
   logic [CNT_W-1:0]      r_lock_cnt;
   logic [CNT_W-1:0]      w_lock_cnt_nxt;
`else
   // Lock inputs are ignored in this build.
   logic                  w_unused_lock;
   assign w_unused_lock = ^core_lock;
`endif

   // Round-robin search over eligible requesters, starting after ptr.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch,
      // so no path can leave a value unassigned and infer a latch.
      w_elig     = core_req & ~r_gnt;
      w_found    = 1'b0;
      w_srch_idx = r_ptr;
      // When a lock ends, the owner sits out the arbitration that follows.
      if (r_state == ST_LOCKED) begin
         w_elig[r_ptr] = 1'b0;
      end
      for (int k = 1; k <= NUM_CORES; k++) begin
         if (!w_found && w_elig[wrap_idx(int'(r_ptr) + k)]) begin
            w_found    = 1'b1;
            w_srch_idx = wrap_idx(int'(r_ptr) + k);
         end
      end
   end

   // Next-state and grant selection: rotation in ARB, owner re-grant in LOCKED.
   always_comb begin
      w_state_nxt = r_state;
      w_gnt_vld   = w_found;
      w_gnt_idx   = w_srch_idx;
`ifdef ARB_LOCK_EN
      w_lock_cnt_nxt = r_lock_cnt;
      case (r_state)
         ST_ARB: begin
            if (w_found && core_lock[w_srch_idx]) begin
               w_state_nxt    = ST_LOCKED;
               w_lock_cnt_nxt = CNT_W'(1);
            end
         end
         ST_LOCKED: begin
            if (core_req[r_ptr] && core_lock[r_ptr] &&
                (r_lock_cnt < CNT_W'(LOCK_MAX))) begin
               w_gnt_vld      = 1'b1;
               w_gnt_idx      = r_ptr;
               w_lock_cnt_nxt = r_lock_cnt + CNT_W'(1);
            end else if (w_found && core_lock[w_srch_idx]) begin
               w_state_nxt    = ST_LOCKED;
               w_lock_cnt_nxt = CNT_W'(1);
            end else begin
               w_state_nxt    = ST_ARB;
               w_lock_cnt_nxt = '0;
            end
         end
         default: begin
            w_state_nxt    = ST_ARB;
            w_lock_cnt_nxt = '0;
         end
      endcase
`endif
   end

   // Grant stage, memory command, and the two-stage acknowledge pipeline.
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous, so it is tested inside the clocked
      // process rather than listed in the sensitivity list.
      if (rst) begin
         r_state     <= ST_ARB;
         r_ptr       <= IDX_W'(NUM_CORES - 1);
         r_gnt       <= '0;
         r_s1_gnt    <= '0;
         r_s1_rd     <= 1'b0;
         r_ack       <= '0;
         r_rdata     <= '0;
         r_mem_en    <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         // NOTE: state uses non-blocking assignments so every register
         // samples pre-edge values, e.g. r_s1_gnt takes the old r_gnt.
         r_state  <= w_state_nxt;
         r_mem_en <= w_gnt_vld;
         r_mem_wr <= w_gnt_vld & core_wr[w_gnt_idx];
         if (w_gnt_vld) begin
            r_ptr       <= w_gnt_idx;
            r_gnt       <= {{(NUM_CORES-1){1'b0}}, 1'b1} << w_gnt_idx;
            r_mem_addr  <= core_addr[w_gnt_idx*ADDR_W +: ADDR_W];
            r_mem_wdata <= core_wdata[w_gnt_idx*DATA_W +: DATA_W];
         end else begin
            r_gnt <= '0;
         end
         r_s1_gnt <= r_gnt;
         r_s1_rd  <= ~r_mem_wr;
         r_ack    <= r_s1_gnt;
         if (|r_s1_gnt && r_s1_rd) begin
            r_rdata <= mem_rdata;
         end
      end
   end

`ifdef ARB_LOCK_EN
   // Lock length counter; saturates the owner's run at LOCK_MAX grants.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lock_cnt <= '0;
      end else begin
         r_lock_cnt <= w_lock_cnt_nxt;
      end
   end
`endif

   assign core_gnt   = r_gnt;
   assign core_ack   = r_ack;
   assign core_rdata = r_rdata;
   assign mem_en     = r_mem_en;
   assign mem_wr     = r_mem_wr;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign busy       = |r_gnt | |r_s1_gnt | |r_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed stimulus pushes expected grants and
// acknowledges into queues; a negedge monitor pops and compares them.
module tb_dmem_arbiter;

   localparam int NC = 4;
   localparam int AW = 8;
   localparam int DW = 16;
   localparam int LM = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [NC-1:0]     core_req;
   logic [NC-1:0]     core_wr;
   logic [NC*AW-1:0]  core_addr;
   logic [NC*DW-1:0]  core_wdata;
   logic [NC-1:0]     core_lock;
   logic [NC-1:0]     core_gnt;
   logic [NC-1:0]     core_ack;
   logic [DW-1:0]     core_rdata;
   logic              mem_en;
   logic              mem_wr;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_wdata;
   logic [DW-1:0]     mem_rdata;
   logic              busy;

   always #5 clk = ~clk;

   dmem_arbiter #(
      .NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)
   ) dut (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_wr(core_wr), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_lock(core_lock),
      .core_gnt(core_gnt), .core_ack(core_ack), .core_rdata(core_rdata),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   // Synchronous RAM model on the memory port.
   logic [DW-1:0] tb_mem [256];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_wr) tb_mem[mem_addr] <= mem_wdata;
         else        mem_rdata <= tb_mem[mem_addr];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int cyc; int idx; logic wr; logic [AW-1:0] addr; } gnt_t;
   typedef struct { int cyc; int idx; logic [DW-1:0] rdata; } ack_t;
   gnt_t gq[$];
   ack_t aq[$];
   gnt_t gm;
   ack_t am;
   int errors = 0;
   int checks = 0;
   logic [DW-1:0] exp_rd = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected grant at cycle c and its acknowledge two cycles later.
   task automatic expect_access(input int c, input int idx, input logic wr,
                                input logic [AW-1:0] a, input logic [DW-1:0] rd);
      gq.push_back('{cyc: c, idx: idx, wr: wr, addr: a});
      if (!wr) exp_rd = rd;
      aq.push_back('{cyc: c + 2, idx: idx, rdata: exp_rd});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic l);
      core_req[i]            = 1'b1;
      core_wr[i]             = w;
      core_addr[i*AW +: AW]  = a;
      core_wdata[i*DW +: DW] = d;
      core_lock[i]           = l;
   endtask

   task automatic release_core(input int i);
      core_req[i]  = 1'b0;
      core_lock[i] = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_gnt"},   core_gnt,   0);
      check({tag, "_ack"},   core_ack,   0);
      check({tag, "_rdata"}, core_rdata, 0);
      check({tag, "_mem_en"}, mem_en,    0);
      check({tag, "_mem_wr"}, mem_wr,    0);
      check({tag, "_mem_addr"}, mem_addr, 0);
      check({tag, "_mem_wdata"}, mem_wdata, 0);
      check({tag, "_busy"},  busy,       0);
   endtask

   // Monitor: compares every grant and acknowledge against the queues.
   always @(negedge clk) begin
      if (core_gnt != '0) begin
         if (gq.size() == 0) begin
            check("gnt_unexpected", core_gnt, 0);
         end else begin
            gm = gq.pop_front();
            check("gnt_cycle", cyc, gm.cyc);
            check("gnt_vec", core_gnt, 32'd1 << gm.idx);
            check("mem_en", mem_en, 1);
            check("mem_wr", mem_wr, gm.wr);
            check("mem_addr", mem_addr, gm.addr);
         end
      end else if (gq.size() != 0 && gq[0].cyc <= cyc) begin
         gm = gq.pop_front();
         check("gnt_missing", core_gnt, 32'd1 << gm.idx);
      end
      if (core_ack != '0) begin
         if (aq.size() == 0) begin
            check("ack_unexpected", core_ack, 0);
         end else begin
            am = aq.pop_front();
            check("ack_cycle", cyc, am.cyc);
            check("ack_vec", core_ack, 32'd1 << am.idx);
            check("ack_rdata", core_rdata, am.rdata);
         end
      end else if (aq.size() != 0 && aq[0].cyc <= cyc) begin
         am = aq.pop_front();
         check("ack_missing", core_ack, 32'd1 << am.idx);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   int n;

   initial begin
      tb_mem[8'h10] = 16'h1234;
      for (int i = 0; i < NC; i++) tb_mem[8'h20 + i] = 16'hA000 + 16'(i);
      tb_mem[8'h30] = 16'h3333;
      tb_mem[8'h05] = 16'h0000;
      tb_mem[8'h40] = 16'h4000;
      tb_mem[8'h41] = 16'h4111;
      tb_mem[8'h42] = 16'h4222;
      tb_mem[8'h50] = 16'h5555;
      core_req = '0; core_wr = '0; core_addr = '0; core_wdata = '0; core_lock = '0;
      rst = 1'b1;
      tick();
      tick();
      check_idle("reset");
      check("reset_ptr", dut.r_ptr, NC - 1);
      rst = 1'b0;

      // Core 2 single read of 0x10.
      drive(2, 1'b0, 8'h10, 16'h0, 1'b0);
      n = cyc;
      expect_access(n + 1, 2, 1'b0, 8'h10, 16'h1234);
      tick();
      release_core(2);
      repeat (3) tick();
      check("ptr_after_core2", dut.r_ptr, 2);

      // All cores request continuously from reset: strict rotation 0,1,2,3.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_rd = '0;
      for (int i = 0; i < NC; i++) drive(i, 1'b0, 8'h20 + 8'(i), 16'h0, 1'b0);
      n = cyc;
      for (int k = 0; k < 8; k++)
         expect_access(n + 1 + k, k % NC, 1'b0, 8'h20 + 8'(k % NC), 16'hA000 + 16'(k % NC));
      repeat (8) tick();
      for (int i = 0; i < NC; i++) release_core(i);
      repeat (3) tick();

      // Single unlocked core 1: grants only on alternate cycles.
      drive(1, 1'b0, 8'h30, 16'h0, 1'b0);
      n = cyc;
      for (int k = 0; k < 3; k++) expect_access(n + 1 + 2 * k, 1, 1'b0, 8'h30, 16'h3333);
      repeat (5) tick();
      release_core(1);
      repeat (3) tick();

      // Core 3 writes 0xBEEF to 0x05, then core 0 reads it back.
      drive(3, 1'b1, 8'h05, 16'hBEEF, 1'b0);
      n = cyc;
      expect_access(n + 1, 3, 1'b1, 8'h05, 16'h0);
      tick();
      release_core(3);
      drive(0, 1'b0, 8'h05, 16'h0, 1'b0);
      expect_access(n + 2, 0, 1'b0, 8'h05, 16'hBEEF);
      tick();
      release_core(0);
      repeat (3) tick();

      // Cores 0,1,2 request; core 1 asks for lock.
      drive(0, 1'b0, 8'h40, 16'h0, 1'b0);
      drive(1, 1'b0, 8'h41, 16'h0, 1'b1);
      drive(2, 1'b0, 8'h42, 16'h0, 1'b0);
      n = cyc;
`ifdef ARB_LOCK_EN
      for (int k = 0; k < LM; k++) expect_access(n + 1 + k, 1, 1'b0, 8'h41, 16'h4111);
      expect_access(n + LM + 1, 2, 1'b0, 8'h42, 16'h4222);
      expect_access(n + LM + 2, 0, 1'b0, 8'h40, 16'h4000);
      repeat (LM + 2) tick();
`else
      expect_access(n + 1, 1, 1'b0, 8'h41, 16'h4111);
      expect_access(n + 2, 2, 1'b0, 8'h42, 16'h4222);
      expect_access(n + 3, 0, 1'b0, 8'h40, 16'h4000);
      repeat (3) tick();
`endif
      for (int i = 0; i < NC; i++) release_core(i);
      repeat (3) tick();

      // Reset while a core 3 read is in the ack stage: its ack is dropped.
      drive(3, 1'b0, 8'h50, 16'h0, 1'b0);
      n = cyc;
      gq.push_back('{cyc: n + 1, idx: 3, wr: 1'b0, addr: 8'h50});
      tick();
      release_core(3);
      tick();
      rst = 1'b1;
      drive(2, 1'b0, 8'h42, 16'h0, 1'b0);
      drive(1, 1'b0, 8'h41, 16'h0, 1'b0);
      tick();
      check_idle("midrst");
      rst = 1'b0;
      exp_rd = '0;
      expect_access(n + 4, 1, 1'b0, 8'h41, 16'h4111);
      expect_access(n + 5, 2, 1'b0, 8'h42, 16'h4222);
      tick();
      release_core(1);
      tick();
      release_core(2);
      repeat (3) tick();

      for (int k = 0; k < 20 && (gq.size() != 0 || aq.size() != 0); k++) tick();
      check("gnt_queue_drained", gq.size(), 0);
      check("ack_queue_drained", aq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
